alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
//
// PURPOSE
//   Shares the single 4-bit ALU between NREQ requesters.
//   Round-robin arbiter and sequencer: takes one request per transaction and
//   issues it to the ALU as a one-cycle start pulse.
//   Waits ALU_LAT cycles, then returns the result tagged with the requester id.
//   Sits between the requesting masters and the alu instance; owns alu OPCODE/OP1/OP2.
//
// PARAMETERS
//   NREQ     4  number of requesters (2..8)
//   DATA_W   4  operand/result width; matches the alu OP1/OP2 width
//   OPC_W    3  opcode width; matches the alu OPCODE width
//   ALU_LAT  1  cycles from the alu_start cycle to a valid alu_result (1..4)
//   ID_W     $clog2(NREQ)  requester id width (derived, not overridable)
//
// PORTS
//   clk          in   1             system clock, rising edge
//   rstn         in   1             synchronous, active-low reset
//   req_valid    in   NREQ          per-requester request valid
//   req_ready    out  NREQ          per-requester accept; one-hot or zero
//   req_opcode   in   NREQ*OPC_W    packed opcodes; requester i at [i*OPC_W +: OPC_W]
//   req_op1      in   NREQ*DATA_W   packed OP1 operands
//   req_op2      in   NREQ*DATA_W   packed OP2 operands
//   alu_opcode   out  OPC_W         to alu OPCODE
//   alu_op1      out  DATA_W        to alu OP1
//   alu_op2      out  DATA_W        to alu OP2
//   alu_start    out  1             one-cycle issue strobe
//   alu_result   in   DATA_W        alu result
//   rsp_valid    out  1             response valid
//   rsp_ready    in   1             response accept
//   rsp_id       out  ID_W          id of the requester that owns the response
//   rsp_result   out  DATA_W        captured alu result
//   rsp_err      out  1             1 = reserved opcode rejected, result forced to 0
//   busy         out  1             FSM state is not IDLE
//
// BEHAVIOUR
//   Reset (rstn=0 at a clk edge)
//     - FSM -> IDLE; rr pointer -> 0; wait counter -> 0.
//     - All outputs 0: req_ready, alu_*, alu_start, rsp_*, busy.
//     - Reset mid-transaction drops the transaction; no response is produced.
//   FSM states: IDLE, ISSUE, WAIT, RESP
//   IDLE
//     - Grant g = first asserted req_valid at or after rr_ptr, searching upward with wrap.
//     - req_ready[g]=1 in the same cycle (combinational); the handshake completes that cycle.
//     - Opcode, operands and g are registered at that edge.
//     - rr_ptr <= (g+1) mod NREQ; rr_ptr is unchanged when nothing is granted.
//     - Next state: ISSUE; or RESP when the opcode is reserved (3'b110, 3'b111).
//   ISSUE
//     - alu_start=1 for exactly one cycle; counter <= ALU_LAT-1; next state WAIT.
//   WAIT
//     - alu_opcode/op1/op2 hold their registered values from ISSUE until the capture edge.
//     - Counter decrements each cycle. At 0, alu_result is captured into rsp_result; next state RESP.
//     - Capture happens in the cycle ALU_LAT after the ISSUE cycle.
//   RESP
//     - rsp_valid=1; rsp_id/rsp_result/rsp_err stay stable until rsp_ready=1.
//     - On handshake: next state IDLE, rsp_valid=0.
//     - Reserved-opcode path: rsp_err=1, rsp_result=0, alu_start never asserted.
//   Timing
//     - Accept at cycle T -> alu_start at T+1 -> rsp_valid at T+2+ALU_LAT (rsp_ready tied 1).
//   Other rules
//     - req_ready is 0 in every state except IDLE; no request is accepted while busy.
//     - req_valid deasserting while not granted is legal; no state is kept per requester.
//     - rsp_ready=1 outside RESP is ignored.
//     - alu_* outputs are 0 whenever the FSM is not in ISSUE or WAIT.
//
// STRUCTURE
//   alu_pkg
//     - localparams DATA_W, OPC_W.
//     - typedef enum for alu opcodes plus the reserved-opcode check function.
//     - typedef enum logic [1:0] for the FSM state.
//   Sub-module rr_arbiter #(N)
//     - Inputs: req[N], ptr[ID_W]. Outputs: gnt_onehot, gnt_id, any.
//     - Purely combinational.
//   alu_arbiter
//     - FSM, operand/id registers, latency counter, response register.
//
// TESTING
//   1. Req0 valid, opcode 3'b100, op1 4'b0100, op2 4'b0000, rsp_ready=1
//      -> req_ready[0] at T, alu_start at T+1 carrying those values.
//      -> rsp_valid at T+3, rsp_id=0, rsp_err=0.
//   2. req_valid=4'b1111 held, rr_ptr=0, rsp_ready=1
//      -> grant order 0,1,2,3,0, one grant every 4 cycles.
//   3. Req2 opcode 3'b111
//      -> rsp_valid at T+1, rsp_err=1, rsp_result=0, alu_start stays 0.
//   4. rsp_ready=0 for 5 cycles in RESP
//      -> rsp_* stable, req_ready=0; acceptance resumes one cycle after the handshake.
//   5. rstn=0 during WAIT
//      -> next cycle busy=0, rsp_valid=0, alu_start=0; the next grant starts at requester 0.
//   6. ALU_LAT=3, single request
//      -> capture 3 cycles after alu_start; operands stable on alu_* for the whole window.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, opcode/state types and the reserved-opcode check for the ALU front-end.
package alu_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OPC_W  = 3;

    typedef enum logic [OPC_W-1:0] {
        OpAdd  = 3'b000,
        OpSub  = 3'b001,
        OpAnd  = 3'b010,
        OpOr   = 3'b011,
        OpXor  = 3'b100,
        OpNot  = 3'b101,
        OpRsv0 = 3'b110,
        OpRsv1 = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StWait  = 2'b10,
        StResp  = 2'b11
    } state_e;

    function automatic logic is_reserved_op(logic [OPC_W-1:0] opc);
        return (opc == OpRsv0) || (opc == OpRsv1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N-1:0]    gnt_onehot_o,
    output logic [ID_W-1:0] gnt_id_o,
    output logic            any_o
);

    logic        found;
    int unsigned cand;

    // Nested loop keeps every bit select constant after unrolling.
    always_comb begin
        gnt_onehot_o = '0;
        gnt_id_o     = '0;
        found        = 1'b0;
        cand         = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (32'(ptr_i) + k) % N;
            for (int unsigned j = 0; j < N; j++) begin
                if (!found && (cand == j) && req_i[j]) begin
                    found           = 1'b1;
                    gnt_onehot_o[j] = 1'b1;
                    gnt_id_o        = ID_W'(j);
                end
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front-end sharing one ALU: accept, issue a start pulse, wait, return tagged result.
module alu_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DATA_W  = alu_pkg::DATA_W,
    parameter int unsigned OPC_W   = alu_pkg::OPC_W,
    parameter int unsigned ALU_LAT = 1,
    localparam int unsigned ID_W   = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*OPC_W-1:0]    req_opcode,
    input  logic [NREQ*DATA_W-1:0]   req_op1,
    input  logic [NREQ*DATA_W-1:0]   req_op2,
    output logic [OPC_W-1:0]         alu_opcode,
    output logic [DATA_W-1:0]        alu_op1,
    output logic [DATA_W-1:0]        alu_op2,
    output logic                     alu_start,
    input  logic [DATA_W-1:0]        alu_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DATA_W-1:0]        rsp_result,
    output logic                     rsp_err,
    output logic                     busy
);

    import alu_pkg::*;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [OPC_W-1:0]    opc_q, opc_d;
    logic [DATA_W-1:0]   op1_q, op1_d;
    logic [DATA_W-1:0]   op2_q, op2_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                err_q, err_d;
    logic [2:0]          cnt_q, cnt_d;

    logic [NREQ-1:0]     gnt_onehot;
    logic [ID_W-1:0]     gnt_id;
    logic                gnt_any;
    logic [OPC_W-1:0]    sel_opc;
    logic [DATA_W-1:0]   sel_op1;
    logic [DATA_W-1:0]   sel_op2;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .req_i        (req_valid),
        .ptr_i        (rr_ptr_q),
        .gnt_onehot_o (gnt_onehot),
        .gnt_id_o     (gnt_id),
        .any_o        (gnt_any)
    );

    assign sel_opc = req_opcode[gnt_id*OPC_W +: OPC_W];
    assign sel_op1 = req_op1[gnt_id*DATA_W +: DATA_W];
    assign sel_op2 = req_op2[gnt_id*DATA_W +: DATA_W];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        opc_d    = opc_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        result_d = result_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_any) begin
                    id_d     = gnt_id;
                    opc_d    = sel_opc;
                    op1_d    = sel_op1;
                    op2_d    = sel_op2;
                    rr_ptr_d = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
                    // Reserved opcodes never reach the ALU; answer straight away with an error.
                    if (is_reserved_op(sel_opc)) begin
                        state_d  = StResp;
                        err_d    = 1'b1;
                        result_d = '0;
                    end else begin
                        state_d = StIssue;
                        err_d   = 1'b0;
                    end
                end
            end
            StIssue: begin
                cnt_d   = 3'(ALU_LAT - 1);
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    result_d = alu_result;
                    state_d  = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            id_q     <= '0;
            opc_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            opc_q    <= opc_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            result_q <= result_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    logic alu_active;
    assign alu_active = (state_q == StIssue) || (state_q == StWait);

    assign req_ready  = (state_q == StIdle) ? gnt_onehot : '0;
    assign alu_start  = (state_q == StIssue);
    assign alu_opcode = alu_active ? opc_q : '0;
    assign alu_op1    = alu_active ? op1_q : '0;
    assign alu_op2    = alu_active ? op2_q : '0;
    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = rsp_valid ? id_q : '0;
    assign rsp_result = rsp_valid ? result_q : '0;
    assign rsp_err    = rsp_valid ? err_q : 1'b0;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: two arbiters (ALU_LAT 1 and 3) sharing stimulus, each with a latency-exact ALU.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [11:0] req_opcode = '0;
    logic [15:0] req_op1 = '0;
    logic [15:0] req_op2 = '0;
    logic        rsp_ready = 1'b0;

    logic [3:0]  req_ready, req_ready3;
    logic [2:0]  alu_opcode, alu_opcode3;
    logic [3:0]  alu_op1, alu_op1_3, alu_op2, alu_op2_3;
    logic        alu_start, alu_start3;
    logic [3:0]  alu_result, alu_result3;
    logic        rsp_valid, rsp_valid3;
    logic [1:0]  rsp_id, rsp_id3;
    logic [3:0]  rsp_result, rsp_result3;
    logic        rsp_err, rsp_err3;
    logic        busy, busy3;

    int checks = 0;
    int errors = 0;
    int age1 = 0;
    int age3 = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(4), .ALU_LAT(1)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_start(alu_start), .alu_result(alu_result), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .busy(busy)
    );

    alu_arbiter #(.NREQ(4), .ALU_LAT(3)) dut3 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready3),
        .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2),
        .alu_opcode(alu_opcode3), .alu_op1(alu_op1_3), .alu_op2(alu_op2_3),
        .alu_start(alu_start3), .alu_result(alu_result3), .rsp_valid(rsp_valid3),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id3), .rsp_result(rsp_result3),
        .rsp_err(rsp_err3), .busy(busy3)
    );

    function automatic logic [3:0] alu_f(logic [2:0] opc, logic [3:0] a, logic [3:0] b);
        case (opc)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // The result is only meaningful in the capture cycle; anything else reads as 4'hA.
    always @(posedge clk) begin
        if (alu_start) age1 <= 1;
        else if (age1 != 0 && age1 < 7) age1 <= age1 + 1;
        if (alu_start3) age3 <= 1;
        else if (age3 != 0 && age3 < 7) age3 <= age3 + 1;
    end
    assign alu_result  = (age1 == 1) ? alu_f(alu_opcode, alu_op1, alu_op2) : 4'hA;
    assign alu_result3 = (age3 == 3) ? alu_f(alu_opcode3, alu_op1_3, alu_op2_3) : 4'hA;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] opc, input logic [3:0] a,
                           input logic [3:0] b);
        req_opcode[i*3 +: 3] = opc;
        req_op1[i*4 +: 4]    = a;
        req_op2[i*4 +: 4]    = b;
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        req_valid = '0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        step();
        checks++;
        if ({busy, rsp_valid, alu_start, rsp_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000", {busy, rsp_valid, alu_start, rsp_err});
        end
        checks++;
        if ({req_ready, alu_op1, alu_op2, alu_opcode, rsp_result} !== 19'd0) begin
            errors++;
            $display("FAIL reset_data got %h want 0",
                     {req_ready, alu_op1, alu_op2, alu_opcode, rsp_result});
        end
        checks++;
        if ({busy3, rsp_valid3, alu_start3, req_ready3} !== 7'd0) begin
            errors++;
            $display("FAIL reset_dut3 got %b want 0", {busy3, rsp_valid3, alu_start3, req_ready3});
        end
        rstn = 1'b1;
    endtask

    task automatic test_single();
        set_req(0, 3'b100, 4'b0100, 4'b0000);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL single_ready got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        checks++;
        if ({alu_start, alu_opcode, alu_op1, alu_op2} !== {1'b1, 3'b100, 4'b0100, 4'b0000}) begin
            errors++;
            $display("FAIL single_issue got %b want 1_100_0100_0000",
                     {alu_start, alu_opcode, alu_op1, alu_op2});
        end
        checks++;
        if ({busy, req_ready} !== 5'b1_0000) begin
            errors++; $display("FAIL single_busy got %b want 10000", {busy, req_ready});
        end
        step();
        checks++;
        if ({alu_start, rsp_valid, alu_op1} !== {2'b00, 4'b0100}) begin
            errors++;
            $display("FAIL single_wait got %b want 000100", {alu_start, rsp_valid, alu_op1});
        end
        step();
        checks++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_result} !== {1'b1, 2'd0, 1'b0, 4'b0100}) begin
            errors++;
            $display("FAIL single_rsp got %b want 1_00_0_0100",
                     {rsp_valid, rsp_id, rsp_err, rsp_result});
        end
        step();
        checks++;
        if ({busy, rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL single_done got %b want 00", {busy, rsp_valid});
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id;
        logic [3:0] exp_mask;
        logic [3:0] exp_res;
        reset_dut();
        for (int i = 0; i < 4; i++) set_req(i, 3'b000, 4'(i), 4'd1);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_id   = 2'(k % 4);
            exp_mask = 4'b0001 << exp_id;
            exp_res  = 4'(exp_id) + 4'd1;
            #1;
            checks++;
            if (req_ready !== exp_mask) begin
                errors++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, exp_mask);
            end
            step();
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++; $display("FAIL rr_busy_ready%0d got %b want 0000", k, req_ready);
            end
            step();
            step();
            checks++;
            if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, exp_id, exp_res}) begin
                errors++;
                $display("FAIL rr_rsp%0d got %b want %b", k, {rsp_valid, rsp_id, rsp_result},
                         {1'b1, exp_id, exp_res});
            end
            step();
        end
        req_valid = '0;
    endtask

    task automatic test_reserved();
        // rr pointer is 1 here, so a lone request 2 is granted.
        set_req(2, 3'b111, 4'd5, 4'd5);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL rsv_ready got %b want 0100", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        checks++;
        if ({rsp_valid, rsp_err, rsp_id, rsp_result, alu_start} !== {2'b11, 2'd2, 4'd0, 1'b0})
        begin
            errors++;
            $display("FAIL rsv_rsp got %b want 11_10_0000_0",
                     {rsp_valid, rsp_err, rsp_id, rsp_result, alu_start});
        end
        step();
        checks++;
        if ({busy, alu_start} !== 2'b00) begin
            errors++; $display("FAIL rsv_done got %b want 00", {busy, alu_start});
        end
    endtask

    task automatic test_backpressure();
        set_req(1, 3'b000, 4'd3, 4'd4);
        set_req(2, 3'b000, 4'd1, 4'd1);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_ready got %b want 0010", req_ready);
        end
        step();
        req_valid = 4'b1111;
        step();
        step();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_result, req_ready} !== {1'b1, 2'd1, 4'd7, 4'd0}) begin
                errors++;
                $display("FAIL bp_hold%0d got %b want 1_01_0111_0000", c,
                         {rsp_valid, rsp_id, rsp_result, req_ready});
            end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, req_ready} !== 5'b1_0000) begin
            errors++; $display("FAIL bp_hs got %b want 10000", {rsp_valid, req_ready});
        end
        step();
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL bp_resume got %b want 0100", req_ready);
        end
        req_valid = '0;
        repeat (4) step();
    endtask

    task automatic test_reset_wait();
        set_req(3, 3'b001, 4'd9, 4'd2);
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL rw_ready got %b want 1000", req_ready);
        end
        step();
        req_valid = '0;
        step();
        checks++;
        if ({busy, alu_op1} !== {1'b1, 4'd9}) begin
            errors++; $display("FAIL rw_inwait got %b want 11001", {busy, alu_op1});
        end
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        #1;
        checks++;
        if ({busy, rsp_valid, alu_start} !== 3'b000) begin
            errors++; $display("FAIL rw_after got %b want 000", {busy, rsp_valid, alu_start});
        end
        step();
        checks++;
        if ({busy, rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL rw_norsp got %b want 00", {busy, rsp_valid});
        end
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL rw_ptr got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        repeat (4) step();
    endtask

    task automatic test_latency3();
        reset_dut();
        set_req(0, 3'b000, 4'd5, 4'd6);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready3 !== 4'b0001) begin
            errors++; $display("FAIL l3_ready got %b want 0001", req_ready3);
        end
        step();
        req_valid = '0;
        #1;
        checks++;
        if ({alu_start3, alu_op1_3, alu_op2_3} !== {1'b1, 4'd5, 4'd6}) begin
            errors++;
            $display("FAIL l3_issue got %b want 1_0101_0110", {alu_start3, alu_op1_3, alu_op2_3});
        end
        for (int w = 0; w < 3; w++) begin
            step();
            checks++;
            if ({alu_start3, rsp_valid3, alu_opcode3, alu_op1_3, alu_op2_3}
                    !== {2'b00, 3'b000, 4'd5, 4'd6}) begin
                errors++;
                $display("FAIL l3_wait%0d got %b want 00_000_0101_0110", w,
                         {alu_start3, rsp_valid3, alu_opcode3, alu_op1_3, alu_op2_3});
            end
        end
        step();
        checks++;
        if ({rsp_valid3, rsp_id3, rsp_result3, alu_op1_3} !== {1'b1, 2'd0, 4'hB, 4'd0}) begin
            errors++;
            $display("FAIL l3_rsp got %b want 1_00_1011_0000",
                     {rsp_valid3, rsp_id3, rsp_result3, alu_op1_3});
        end
        step();
        checks++;
        if (busy3 !== 1'b0) begin
            errors++; $display("FAIL l3_done got %b want 0", busy3);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_reserved();
        test_backpressure();
        test_reset_wait();
        test_latency3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
